uart_rx_frame: RTL

//  Serial receiver that feeds the sensor-poll FSM and the checksum stage.
//  - Deserialises two consecutive 8N1 UART bytes from the sensor into one 16-bit response.
//  - Byte 0 is the sensor reading; byte 1 is its CRC.
//  - Reports frame completion, framing errors and inter-byte timeouts.

---
 rtl/uart_rx_frame.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - two-byte 8N1 UART receiver producing a 16-bit sensor response
module uart_rx_frame #(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx,
    output logic [15:0] data,
    output logic        done,
    output logic        busy,
    output logic        frame_err,
    output logic        timeout
);

    localparam int TO_CYCLES = CLKS_PER_BIT * TIMEOUT_BITS;
    localparam int CW        = $clog2(TO_CYCLES + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] TO_CNT  = CW'(TO_CYCLES);

    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP, GAP, WAIT_HIGH
    } state_t;

    state_t        state, state_n;
    logic          rx_q, rx_s;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic          byte_idx, byte_idx_n;
    logic [7:0]    shift, shift_n;
    logic [7:0]    byte0, byte0_n;
    logic [15:0]   data_n;
    logic          done_n, frame_err_n, timeout_n;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_q      <= 1'b1;
            rx_s      <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            byte_idx  <= 1'b0;
            shift     <= '0;
            byte0     <= '0;
            data      <= '0;
            done      <= 1'b0;
            frame_err <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            rx_q      <= rx;
            rx_s      <= rx_q;
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_idx_n;
            byte_idx  <= byte_idx_n;
            shift     <= shift_n;
            byte0     <= byte0_n;
            data      <= data_n;
            done      <= done_n;
            frame_err <= frame_err_n;
            timeout   <= timeout_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        bit_idx_n   = bit_idx;
        byte_idx_n  = byte_idx;
        shift_n     = shift;
        byte0_n     = byte0;
        data_n      = data;
        done_n      = 1'b0;
        frame_err_n = 1'b0;
        timeout_n   = 1'b0;
        case (state)
            IDLE: begin
                cnt_n      = '0;
                byte_idx_n = 1'b0;
                if (!rx_s) state_n = START;
            end
            START: begin
                if (cnt == HALF_M1) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = rx_s ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DATA: begin
                if (cnt == BIT_M1) begin
                    cnt_n   = '0;
                    shift_n = {rx_s, shift[7:1]};
                    if (bit_idx == 3'd7) state_n = STOP;
                    else                 bit_idx_n = bit_idx + 3'd1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            STOP: begin
                if (cnt == BIT_M1) begin
                    cnt_n = '0;
                    if (!rx_s) begin
                        frame_err_n = 1'b1;
                        state_n     = WAIT_HIGH;
                    end else if (!byte_idx) begin
                        byte0_n = shift;
                        state_n = GAP;
                    end else begin
                        data_n  = {shift, byte0};
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            GAP: begin
                // Timeout wins over a start edge arriving in the same cycle.
                if (cnt == TO_CNT) begin
                    timeout_n = 1'b1;
                    cnt_n     = '0;
                    state_n   = IDLE;
                end else if (!rx_s) begin
                    cnt_n      = '0;
                    byte_idx_n = 1'b1;
                    state_n    = START;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            WAIT_HIGH: begin
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state != IDLE) && (state != WAIT_HIGH);

endmodule
